// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the fetch-side branch predictor.
// Counter encodings follow the classic 2-bit bimodal scheme; the MSB is the taken prediction.
package branch_predictor_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned BHT_ENTRIES_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 32;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  // Both taken-side states predict taken.
  function automatic logic cnt_predicts_taken(input bht_cnt_e c);
    return (c == BHT_WT) || (c == BHT_ST);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and resolution bus between fetch/execute and the branch predictor.
// master = fetch/execute side, slave = predictor.
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             pred_req;
  logic [XLEN-1:0]  pred_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  logic             upd_valid;
  logic [XLEN-1:0]  upd_pc;
  logic             upd_taken;
  logic [XLEN-1:0]  upd_target;
  logic             upd_pred_taken;
  logic [XLEN-1:0]  upd_pred_target;

  logic             mispredict;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output pred_req, pred_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_valid, pred_taken, pred_target,
    input  mispredict, mispredict_cnt
  );

  modport slave (
    input  pred_req, pred_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_valid, pred_taken, pred_target,
    output mispredict, mispredict_cnt
  );

endinterface

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bht_cnt_e cur,
  input  logic     taken,
  output bht_cnt_e nxt
);

  always_comb begin : next_state
    nxt = cur;
    if (taken) begin
      if (cur != BHT_ST) nxt = bht_cnt_e'(2'(cur) + 2'd1);
    end else begin
      if (cur != BHT_SNT) nxt = bht_cnt_e'(2'(cur) - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with tag/target table, trained from execute.
// Lookups read the table before any same-cycle update commits.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  bht_cnt_e               cnt_q    [BHT_ENTRIES];
  logic [TAG_W-1:0]       tag_q    [BHT_ENTRIES];
  logic [XLEN-1:0]        target_q [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] valid_q;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [XLEN-1:0]  pred_target_q;
  logic             mispredict_q;
  logic [CNT_W-1:0] miss_cnt_q;

  logic [IDX_W-1:0] lk_idx_c;
  logic [TAG_W-1:0] lk_tag_c;
  logic             lk_taken_c;
  logic [IDX_W-1:0] up_idx_c;
  logic [TAG_W-1:0] up_tag_c;
  logic             up_hit_c;
  logic             mp_c;
  bht_cnt_e         cnt_nxt_c;
  logic [3:0]       unused_pc_lsbs;

  assign unused_pc_lsbs = {bus.pred_pc[1:0], bus.upd_pc[1:0]};

  // Lookup path
  assign lk_idx_c   = bus.pred_pc[IDX_W+1:2];
  assign lk_tag_c   = bus.pred_pc[XLEN-1:IDX_W+2];
  assign lk_taken_c = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c)
                      && cnt_predicts_taken(cnt_q[lk_idx_c]);

  // Update path
  assign up_idx_c = bus.upd_pc[IDX_W+1:2];
  assign up_tag_c = bus.upd_pc[XLEN-1:IDX_W+2];
  assign up_hit_c = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);

  assign mp_c = (bus.upd_taken != bus.upd_pred_taken)
                || (bus.upd_taken && (bus.upd_pred_target != bus.upd_target));

  sat_counter2 u_sat_counter2 (
    .cur   (cnt_q[up_idx_c]),
    .taken (bus.upd_taken),
    .nxt   (cnt_nxt_c)
  );

  // Table state: train on hit, allocate on taken miss, ignore not-taken miss
  always_ff @(posedge clk or negedge rst_n) begin : table_ff
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        cnt_q[i]    <= BHT_WNT;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (bus.upd_valid) begin
      if (up_hit_c) begin
        cnt_q[up_idx_c] <= cnt_nxt_c;
        if (bus.upd_taken) target_q[up_idx_c] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[up_idx_c]  <= 1'b1;
        tag_q[up_idx_c]    <= up_tag_c;
        cnt_q[up_idx_c]    <= BHT_WT;
        target_q[up_idx_c] <= bus.upd_target;
      end
    end
  end

  // Prediction outputs hold between requests
  always_ff @(posedge clk or negedge rst_n) begin : pred_ff
    if (!rst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q <= bus.pred_req;
      if (bus.pred_req) begin
        pred_taken_q  <= lk_taken_c;
        pred_target_q <= lk_taken_c ? target_q[lk_idx_c] : '0;
      end
    end
  end

  // Misprediction pulse and saturating performance count
  always_ff @(posedge clk or negedge rst_n) begin : miss_ff
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      mispredict_q <= bus.upd_valid && mp_c;
      if (bus.upd_valid && mp_c && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.pred_target    = pred_target_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.mispredict_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// scored against a behavioural table model; small counter width exposes saturation.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned IDXW    = 6;
  localparam int          CNT_MAX = 15;

  logic clk;
  logic rst_n;

  branch_predictor_if #(.XLEN(32), .CNT_W(4)) bus ();

  branch_predictor #(
    .XLEN        (32),
    .BHT_ENTRIES (ENTRIES),
    .CNT_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Behavioural model: counters as integers 0..3, taken when >= 2
  int          mcnt [ENTRIES];
  bit          mval [ENTRIES];
  logic [31:0] mtag [ENTRIES];
  logic [31:0] mtgt [ENTRIES];
  logic        e_pv;
  logic        e_pt;
  logic [31:0] e_ptgt;
  logic        e_mp;
  int          e_cnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDXW + 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      mcnt[i] = 1;
      mval[i] = 1'b0;
      mtag[i] = '0;
      mtgt[i] = '0;
    end
    e_pv   = 1'b0;
    e_pt   = 1'b0;
    e_ptgt = '0;
    e_mp   = 1'b0;
    e_cnt  = 0;
  endtask

  task automatic step(input logic req, input logic [31:0] pc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
    int i;
    bit hit;
    bit mp;
    e_pv = req;
    if (req) begin
      i      = idx_of(pc);
      hit    = mval[i] && (mtag[i] == tag_of(pc));
      e_pt   = hit && (mcnt[i] >= 2);
      e_ptgt = e_pt ? mtgt[i] : 32'h0;
    end
    e_mp = 1'b0;
    if (uv) begin
      mp   = (ut != upt) || (ut && (uptgt != utgt));
      e_mp = mp;
      if (mp && e_cnt < CNT_MAX) e_cnt++;
      i   = idx_of(upc);
      hit = mval[i] && (mtag[i] == tag_of(upc));
      if (hit) begin
        mcnt[i] = ut ? ((mcnt[i] + 1 > 3) ? 3 : mcnt[i] + 1)
                     : ((mcnt[i] - 1 < 0) ? 0 : mcnt[i] - 1);
        if (ut) mtgt[i] = utgt;
      end else if (ut) begin
        mval[i] = 1'b1;
        mtag[i] = tag_of(upc);
        mcnt[i] = 2;
        mtgt[i] = utgt;
      end
    end
    bus.pred_req        = req;
    bus.pred_pc         = pc;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;
    @(posedge clk);
    #1;
    chk("pred_valid",  32'(bus.pred_valid),     32'(e_pv));
    chk("pred_taken",  32'(bus.pred_taken),     32'(e_pt));
    chk("pred_target", bus.pred_target,         e_ptgt);
    chk("mispredict",  32'(bus.mispredict),     32'(e_mp));
    chk("miss_cnt",    32'(bus.mispredict_cnt), 32'(e_cnt));
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
    step(1'b0, 32'h0, 1'b1, pc, t, tgt, pt, ptgt);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pv"},  32'(bus.pred_valid),     32'h0);
    chk({tag, "_pt"},  32'(bus.pred_taken),     32'h0);
    chk({tag, "_tgt"}, bus.pred_target,         32'h0);
    chk({tag, "_mp"},  32'(bus.mispredict),     32'h0);
    chk({tag, "_cnt"}, 32'(bus.mispredict_cnt), 32'h0);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rupc;
    logic [31:0] rtgt;
    logic        rt;
    logic        rpt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.pred_req        = 1'b0;
    bus.pred_pc         = '0;
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Cold lookup predicts not-taken
    lookup(32'h100);
    chk("cold_taken", 32'(bus.pred_taken), 32'h0);

    // First taken resolution allocates and counts a mispredict
    update(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    chk("alloc_mp",  32'(bus.mispredict),     32'h1);
    chk("alloc_cnt", 32'(bus.mispredict_cnt), 32'h1);
    idle();
    chk("mp_pulse_end", 32'(bus.mispredict), 32'h0);
    lookup(32'h100);
    chk("alloc_taken",  32'(bus.pred_taken), 32'h1);
    chk("alloc_target", bus.pred_target,     32'h80);

    // Saturate down, then one taken step back up stays not-taken
    for (int k = 0; k < 4; k++) update(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    lookup(32'h100);
    chk("snt_taken", 32'(bus.pred_taken), 32'h0);
    update(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    lookup(32'h100);
    chk("wnt_taken", 32'(bus.pred_taken), 32'h0);

    // Aliasing entry: tag miss, then replacement
    update(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    lookup(32'h100);
    chk("retrain_taken", 32'(bus.pred_taken), 32'h1);
    lookup(32'h200);
    chk("alias_miss", 32'(bus.pred_taken), 32'h0);
    update(32'h200, 1'b1, 32'h40, 1'b0, 32'h0);
    lookup(32'h100);
    chk("evicted_miss", 32'(bus.pred_taken), 32'h0);
    lookup(32'h200);
    chk("alias_target", bus.pred_target, 32'h40);

    // Same-cycle lookup and update read the pre-update entry
    update(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h80);
    chk("rbw_taken",  32'(bus.pred_taken), 32'h1);
    chk("rbw_target", bus.pred_target,     32'h80);
    lookup(32'h100);
    chk("rbw_after", bus.pred_target, 32'h300);
    update(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    lookup(32'h100);
    chk("st_to_wt_taken", 32'(bus.pred_taken), 32'h1);

    // Random traffic over a few indices and aliasing tags
    for (int n = 0; n < 400; n++) begin
      rpc  = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      rupc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 7)) << 2);
      rtgt = 32'($urandom) & 32'h0000_FFFC;
      rt   = 1'($urandom_range(0, 1));
      rpt  = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), rpc, 1'($urandom_range(0, 1)), rupc, rt, rtgt,
           rpt, ($urandom_range(0, 1) != 0) ? rtgt : (rtgt ^ 32'h4));
    end

    // Saturation of the miss counter, then asynchronous reset mid-stream
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) update(32'h40, 1'b1, 32'h10, 1'b0, 32'h0);
    chk("miss_sat", 32'(bus.mispredict_cnt), 32'hF);
    lookup(32'h40);
    chk("sat_entry_taken", 32'(bus.pred_taken), 32'h1);
    update(32'h40, 1'b1, 32'h10, 1'b0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    #2;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h40);
    chk("post_rst_taken", 32'(bus.pred_taken), 32'h0);
    chk("post_rst_pv",    32'(bus.pred_valid), 32'h1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor; the producer end of the branch-outcome path that the execute-stage comparator resolves.
- Predicts taken/not-taken and target for the fetch PC using a direct-mapped table of 2-bit saturating counters, tags and targets.
- Trains from execute-stage resolution: the comparator outcome plus the computed target.
- Counts mispredictions for the performance CSRs.

Parameters:
- XLEN, `XLEN (32): address/data width.
- BHT_ENTRIES, 64: table depth; power of two, at least 4. IDX_W = $clog2(BHT_ENTRIES).
- CNT_W, 32: misprediction counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pred_req  in  1  fetch lookup request
- pred_pc  in  XLEN  fetch PC, word aligned
- pred_valid  out  1  prediction valid; one cycle after pred_req
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted target; 0 when not taken
- upd_valid  in  1  execute-stage branch resolved this cycle
- upd_pc  in  XLEN  PC of the resolved branch
- upd_taken  in  1  comparator outcome
- upd_target  in  XLEN  resolved target
- upd_pred_taken  in  1  prediction fetch made for this branch
- upd_pred_target  in  XLEN  target fetch used
- mispredict  out  1  registered pulse: direction mismatch, or taken with target mismatch
- mispredict_cnt  out  CNT_W  saturating misprediction count

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset state:
  - all counters = 2'b01 (weakly not-taken), all valid bits = 0, tags/targets = 0
  - pred_valid = 0, pred_taken = 0, pred_target = 0
  - mispredict = 0, mispredict_cnt = 0
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
- Lookup (1-cycle latency), registered on the edge where pred_req = 1:
  - hit = valid[idx] && tag[idx] == tag(pred_pc)
  - pred_taken = hit && cnt[idx][1]
  - pred_target = pred_taken ? target[idx] : 0
  - pred_valid = 1 the next cycle, else 0. pred_taken/pred_target hold their value when pred_req = 0.
- Update, on the edge where upd_valid = 1, entry i = idx(upd_pc):
  - Tag hit: cnt[i] saturates up (max 2'b11) if upd_taken, down (min 2'b00) otherwise.
  - Tag miss or invalid, upd_taken = 1: allocate. valid = 1, tag written, cnt = 2'b10, target = upd_target.
  - Tag miss, upd_taken = 0: no state change.
  - Target written on every taken update.
- Simultaneous lookup and update, same index: lookup returns the pre-update entry (read-before-write). The update still commits.
- Misprediction, evaluated when upd_valid = 1:
  - mp = (upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target)
  - mispredict = mp, registered one cycle after upd_valid; 0 when upd_valid = 0.
  - mispredict_cnt increments on mp and saturates at all-ones; it does not wrap.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first lookup after deassertion returns not-taken.
- No stall input: fetch owns the pred_req timing, and a dropped prediction is harmless.

Decomposition:
- Additions to constants.vh:
  - counter encodings BHT_SNT = 2'b00, BHT_WNT = 2'b01, BHT_WT = 2'b10, BHT_ST = 2'b11
  - BHT_ENTRIES default
- Sub-module sat_counter2: purely combinational next-state (cur, taken -> next), instantiated once in the update path. Arrays and counters stay in branch_predictor.

Test Plan:
- Reset, then pred_req with pred_pc = 0x100 -> next cycle pred_valid = 1, pred_taken = 0, pred_target = 0. mispredict_cnt = 0.
- Update pc 0x100, taken, target 0x80, upd_pred_taken = 0 -> mispredict pulses 1 cycle, cnt = 1. Lookup 0x100 -> taken, target 0x80.
- Four not-taken updates at 0x100 -> counter 10 -> 01 -> 00 -> 00 (held). Lookup not-taken. A further taken update gives 01, lookup still not-taken.
- Alias pc 0x100 + 4*BHT_ENTRIES (0x200 at default) after 0x100 is trained taken -> lookup 0x200 is not-taken (tag miss). Taken update at 0x200 replaces the entry, and 0x100 then misses.
- Same-cycle lookup and update of 0x100 (WT to ST) -> prediction shows the pre-update entry; the next lookup shows ST.
- Force mispredict_cnt to near all-ones (CNT_W = 4 build), apply 20 mispredicts -> saturates at 4'hF. Assert rst_n low mid-sequence -> all outputs 0 asynchronously.
